// File: rtl/alu_issue_unit_if.sv
// Bundles the request, host-init, ALU-side and write-back signals of alu_issue_unit.
// Latency: none; this is wiring only.
// Backpressure: req_valid/req_ready handshake; init, ALU and write-back paths have no flow control.
//
// Modports:
//   slave  - the issue unit: takes requests, init writes and alu_result; drives req_ready,
//            ALU operands and the write-back strobe.
//   master - the surrounding host and ALU: drives requests, init writes and alu_result.
interface alu_issue_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPRN_WIDTH     = 6,
  parameter int REG_ADDR_WIDTH = 5
);
  // request handshake
  logic                      req_valid;
  logic                      req_ready;
  logic [OPRN_WIDTH-1:0]     req_oprn;
  logic [REG_ADDR_WIDTH-1:0] req_rs;
  logic [REG_ADDR_WIDTH-1:0] req_rt;
  logic [REG_ADDR_WIDTH-1:0] req_rd;

  // host register-file write port
  logic                      init_we;
  logic [REG_ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0]     init_data;

  // ALU connection
  logic [DATA_WIDTH-1:0]     alu_op1;
  logic [DATA_WIDTH-1:0]     alu_op2;
  logic [OPRN_WIDTH-1:0]     alu_oprn;
  logic [DATA_WIDTH-1:0]     alu_result;

  // write-back
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;

  modport slave (
    input  req_valid, req_oprn, req_rs, req_rt, req_rd,
    input  init_we, init_addr, init_data,
    input  alu_result,
    output req_ready,
    output alu_op1, alu_op2, alu_oprn,
    output wb_valid, wb_rd, wb_data
  );

  modport master (
    output req_valid, req_oprn, req_rs, req_rt, req_rd,
    output init_we, init_addr, init_data,
    output alu_result,
    input  req_ready,
    input  alu_op1, alu_op2, alu_oprn,
    input  wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Operand-fetch / write-back sequencer with a 2^REG_ADDR_WIDTH-entry register file in front of a combinational ALU.
// Latency: accept -> wb_valid in 2 cycles; one operation every 4 cycles with req_valid held high.
// Backpressure: req_ready is high only in IDLE; a request offered while busy is held off, never dropped or duplicated.
//
// Ports:
//   CLK, RST   - clock, asynchronous active-high reset (clears FSM, outputs and register file)
//   bus.slave  - req_* handshake in, init_* host writes in (honoured in IDLE only),
//                alu_op1/alu_op2/alu_oprn registered out, alu_result in,
//                wb_valid/wb_rd/wb_data write-back out
//
// Build option ALU_ISSUE_REG0_ZERO_EN: when defined, register 0 reads as zero and
// writes to it are dropped (the write-back strobe still pulses for rd=0).
module alu_issue_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPRN_WIDTH     = 6,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RST,
  alu_issue_unit_if.slave  bus
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // latched request fields, valid from READ onward
  logic [OPRN_WIDTH-1:0]     oprn_q;
  logic [REG_ADDR_WIDTH-1:0] rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  logic [DATA_WIDTH-1:0]     regs [NUM_REGS];

  logic                      accept;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;
  logic [DATA_WIDTH-1:0]     rd_port1;
  logic [DATA_WIDTH-1:0]     rd_port2;

  // ---------------------------------------------------------------------------
  // FSM next state, handshake/strobe outputs and the single register-file
  // write port. Host writes (IDLE) and write-back (WB) live in different
  // states, so one port covers both without arbitration.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    accept        = 1'b0;
    rf_we         = 1'b0;
    rf_waddr      = bus.init_addr;
    rf_wdata      = bus.init_data;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        accept        = bus.req_valid;
        rf_we         = bus.init_we;
        if (bus.req_valid) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = EXEC;
      end
      EXEC: begin
        state_d = WB;
      end
      WB: begin
        bus.wb_valid = 1'b1;
        rf_we        = 1'b1;
        rf_waddr     = bus.wb_rd;
        rf_wdata     = bus.wb_data;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef ALU_ISSUE_REG0_ZERO_EN
    // r0 is hard-wired to zero: drop every write aimed at it
    if (rf_waddr == '0) begin
      rf_we = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file read ports. A same-edge init write in the accept cycle has
  // landed by READ, so READ always sees it.
  // ---------------------------------------------------------------------------
`ifdef ALU_ISSUE_REG0_ZERO_EN
  assign rd_port1 = (rs_q == '0) ? '0 : regs[rs_q];
  assign rd_port2 = (rt_q == '0) ? '0 : regs[rt_q];
`else
  assign rd_port1 = regs[rs_q];
  assign rd_port2 = regs[rt_q];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs <= '{default: '0};
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. Each group loads only in its own state and otherwise
  // holds, so the ALU inputs stay stable across EXEC and the write-back
  // fields stay stable across WB.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oprn_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      oprn_q <= bus.req_oprn;
      rs_q   <= bus.req_rs;
      rt_q   <= bus.req_rt;
      rd_q   <= bus.req_rd;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.alu_op1  <= '0;
      bus.alu_op2  <= '0;
      bus.alu_oprn <= '0;
    end else if (state_q == READ) begin
      bus.alu_op1  <= rd_port1;
      bus.alu_op2  <= rd_port2;
      bus.alu_oprn <= oprn_q;
    end
  end

  // The result is captured untouched; the unit never decodes oprn, so an
  // undefined code passes whatever the ALU drives (X included) straight on.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.wb_data <= '0;
      bus.wb_rd   <= '0;
    end else if (state_q == EXEC) begin
      bus.wb_data <= bus.alu_result;
      bus.wb_rd   <= rd_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural ALU on alu_result.
// Latency: expects wb_valid exactly 2 cycles after each accept.
// Backpressure: requests are held until req_ready; some are issued back-to-back with req_valid held high.
module tb_alu_issue_unit;

  logic CLK;
  logic RST;
  int   cyc;
  int   n_vec;
  int   n_bad;

  alu_issue_unit_if #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .REG_ADDR_WIDTH(5)) bus ();

  alu_issue_unit #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .REG_ADDR_WIDTH(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // behavioural ALU: codes used by the test plan, X for anything else
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    case (op)
      6'h01:   return a + b;
      6'h02:   return a - b;
      6'h03:   return a * b;
      6'h07:   return (a < b) ? 32'd1 : 32'd0;
      6'h08:   return a << b[4:0];
      default: return 'x;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_op1, bus.alu_op2, bus.alu_oprn);

  // reference register file
  logic [31:0] mreg [32];

  function automatic logic [31:0] model_rd(input logic [4:0] a);
`ifdef ALU_ISSUE_REG0_ZERO_EN
    if (a == 5'd0) return 32'd0;
`endif
    return mreg[a];
  endfunction

  task automatic model_wr(input logic [4:0] a, input logic [31:0] d);
`ifdef ALU_ISSUE_REG0_ZERO_EN
    if (a == 5'd0) return;
`endif
    mreg[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] acc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // write-back monitor: every strobe must match the oldest expectation
  always @(negedge CLK) begin
    if (bus.wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_wb", 32'(bus.wb_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
        chk("wb_data", bus.wb_data, e.data);
        chk("wb_latency", 32'(cyc) - e.acc, 32'd2);
      end
    end
  end

  task automatic init_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus.init_we   = 1'b1;
    bus.init_addr = a;
    bus.init_data = d;
    @(posedge CLK);
    #1;
    bus.init_we = 1'b0;
    model_wr(a, d);
  endtask

  // Offer a request and return just after the accepting edge. waits counts
  // the not-ready cycles seen before acceptance.
  task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit hold, input bit push,
                       input bit do_init, input logic [4:0] ia, input logic [31:0] id,
                       output int waits);
    logic [31:0] e;
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_oprn  = op;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
    bus.req_rd    = rd;
    bus.init_we   = do_init;
    bus.init_addr = ia;
    bus.init_data = id;
    waits = 0;
    while (bus.req_ready !== 1'b1 && waits < 40) begin
      @(negedge CLK);
      waits++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      bus.init_we   = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    if (do_init) model_wr(ia, id);
    if (push) begin
      e = alu_f(model_rd(rs), model_rd(rt), op);
      sb.push_back({rd, e, 32'(cyc)});
      model_wr(rd, e);
    end
    bus.init_we = 1'b0;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic op1(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    int w;
    issue(op, rs, rt, rd, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    while ((sb.size() != 0 || bus.req_ready !== 1'b1) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0 || bus.req_ready !== 1'b1) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({pfx, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({pfx, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
    chk({pfx, "_wb_data"}, bus.wb_data, 32'd0);
    chk({pfx, "_alu_op1"}, bus.alu_op1, 32'd0);
    chk({pfx, "_alu_op2"}, bus.alu_op2, 32'd0);
    chk({pfx, "_alu_oprn"}, 32'(bus.alu_oprn), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "global timeout");
  end

  initial begin
    int w1;
    int w2;
    n_vec = 0;
    n_bad = 0;
    RST = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_oprn  = '0;
    bus.req_rs    = '0;
    bus.req_rt    = '0;
    bus.req_rd    = '0;
    bus.init_we   = 1'b0;
    bus.init_addr = '0;
    bus.init_data = '0;
    model_clear();

    repeat (3) @(negedge CLK);
    chk_zero_outputs("reset");
    RST = 1'b0;

    // add, then a follow-up reading the result plus r0
    init_write(5'd1, 32'd15);
    init_write(5'd2, 32'd3);
    op1(6'h01, 5'd1, 5'd2, 5'd3);
    drain();
    op1(6'h01, 5'd3, 5'd0, 5'd4);
    drain();

    // back-to-back dependency with req_valid held high
    init_write(5'd1, 32'd10);
    init_write(5'd2, 32'd5);
    init_write(5'd7, 32'd2);
    issue(6'h02, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, w1);
    issue(6'h03, 5'd3, 5'd7, 5'd4, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, w2);
    chk("b2b_ready_low_cycles", 32'(w2), 32'd3);
    drain();

    // shift; check the registered ALU inputs during EXEC
    init_write(5'd5, 32'd8);
    init_write(5'd6, 32'd2);
    op1(6'h08, 5'd5, 5'd6, 5'd10);
    @(posedge CLK);
    @(negedge CLK);
    chk("exec_alu_oprn", 32'(bus.alu_oprn), 32'h08);
    chk("exec_alu_op1", bus.alu_op1, 32'd8);
    chk("exec_alu_op2", bus.alu_op2, 32'd2);
    drain();

    // compare both ways
    init_write(5'd1, 32'd15);
    init_write(5'd8, 32'd5);
    op1(6'h07, 5'd1, 5'd8, 5'd11);
    drain();
    op1(6'h07, 5'd8, 5'd1, 5'd12);
    drain();

    // rs == rt
    op1(6'h01, 5'd5, 5'd5, 5'd13);
    drain();

    // r0 protection (model applies the same build option)
    init_write(5'd0, 32'd99);
    init_write(5'd14, 32'd7);
    op1(6'h01, 5'd14, 5'd31, 5'd0);
    drain();
    op1(6'h01, 5'd0, 5'd31, 5'd15);
    drain();

    // undefined oprn: result passes through as X
    op1(6'h3F, 5'd1, 5'd2, 5'd20);
    drain();

    // init write in the accept cycle is visible to READ
    issue(6'h01, 5'd10, 5'd31, 5'd16, 1'b0, 1'b1, 1'b1, 5'd10, 32'd77, w1);
    drain();

    // init writes while busy are ignored
    op1(6'h01, 5'd1, 5'd2, 5'd21);
    bus.init_we   = 1'b1;
    bus.init_addr = 5'd9;
    bus.init_data = 32'd55;
    repeat (3) @(posedge CLK);
    #1;
    bus.init_we = 1'b0;
    drain();
    op1(6'h01, 5'd9, 5'd31, 5'd22);
    drain();
    init_write(5'd9, 32'd55);
    op1(6'h01, 5'd9, 5'd31, 5'd23);
    drain();

    // reset during EXEC abandons the write-back and clears everything
    init_write(5'd17, 32'd4);
    issue(6'h01, 5'd17, 5'd17, 5'd24, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w1);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    @(negedge CLK);
    RST = 1'b0;
    model_clear();
    @(negedge CLK);
    chk("post_reset_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) @(negedge CLK);
    op1(6'h01, 5'd24, 5'd17, 5'd25);
    drain();

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
